// File: rtl/trap_controller.sv
// Trap controller: owns privilege mode and the trap CSRs, sequences trap entry
// and xRET, then hands a flush plus PC redirect to IF over a valid/ready pair.
module trap_controller #(
    parameter int unsigned XLEN         = 32,
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            exception_i,
    input  logic [4:0]      exception_code_i,
    input  logic [XLEN-1:0] exception_pc_i,
    input  logic [XLEN-1:0] exception_val_i,
    input  logic            mret_i,
    input  logic            sret_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_o,
    output logic            busy_o,
    output logic [1:0]      current_priv_o,
    output logic            mstatus_mie_o,
    output logic            mstatus_sie_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [XLEN-1:0] MASK_B0  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] MASK_B10 = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      priv_q;
    logic            sie_q, mie_q, spie_q, mpie_q, spp_q;
    logic [1:0]      mpp_q;
    logic [15:0]     medeleg_q;
    logic [XLEN-1:0] mtvec_q, stvec_q, mepc_q, sepc_q;
    logic [XLEN-1:0] mcause_q, scause_q, mtval_q, stval_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            redirect_valid_q, flush_q, busy_q;

    logic            idle_s, take_exc_s, take_mret_s, take_sret_s, csr_wr_s, deleg_s;
    logic [XLEN-1:0] epc_s, cause_s, mstatus_s;
    logic [1:0]      wr_mpp_s;
    logic [XLEN-1:0] redirect_pc_d;

    // Event arbitration: exception beats mret beats sret, all only in IDLE
    always_comb begin
        idle_s      = (state_q == ST_IDLE);
        take_exc_s  = idle_s && exception_i;
        take_mret_s = idle_s && !exception_i && mret_i;
        take_sret_s = idle_s && !exception_i && !mret_i && sret_i;
        csr_wr_s    = idle_s && csr_we_i;
        deleg_s     = (priv_q != PRIV_M) && !exception_code_i[4]
                      && medeleg_q[exception_code_i[3:0]];
        epc_s       = exception_pc_i & MASK_B0;
        cause_s     = {{(XLEN-5){1'b0}}, exception_code_i};
        wr_mpp_s    = (csr_wdata_i[12:11] == 2'b10) ? 2'b00 : csr_wdata_i[12:11];
    end

    // Redirect target chosen at the accepting edge; vectors and epcs hold zero low bits
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        if (take_exc_s) begin
            redirect_pc_d = deleg_s ? stvec_q : mtvec_q;
        end else if (take_mret_s) begin
            redirect_pc_d = mepc_q;
        end else if (take_sret_s) begin
            redirect_pc_d = sepc_q;
        end else begin
            redirect_pc_d = redirect_pc_q;
        end
    end

    // Packed mstatus view with only the trap-related fields implemented
    always_comb begin
        mstatus_s        = {XLEN{1'b0}};
        mstatus_s[1]     = sie_q;
        mstatus_s[3]     = mie_q;
        mstatus_s[5]     = spie_q;
        mstatus_s[7]     = mpie_q;
        mstatus_s[8]     = spp_q;
        mstatus_s[12:11] = mpp_q;
    end

    // CSR read mux
    always_comb begin
        case (csr_addr_i)
            CSR_MSTATUS: csr_rdata_o = mstatus_s;
            CSR_MEDELEG: csr_rdata_o = {{(XLEN-16){1'b0}}, medeleg_q};
            CSR_MTVEC:   csr_rdata_o = mtvec_q;
            CSR_MEPC:    csr_rdata_o = mepc_q;
            CSR_MCAUSE:  csr_rdata_o = mcause_q;
            CSR_MTVAL:   csr_rdata_o = mtval_q;
            CSR_STVEC:   csr_rdata_o = stvec_q;
            CSR_SEPC:    csr_rdata_o = sepc_q;
            CSR_SCAUSE:  csr_rdata_o = scause_q;
            CSR_STVAL:   csr_rdata_o = stval_q;
            default:     csr_rdata_o = {XLEN{1'b0}};
        endcase
    end

    // State machine, CSR file and registered redirect outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            priv_q           <= PRIV_M;
            sie_q            <= 1'b0;
            mie_q            <= 1'b0;
            spie_q           <= 1'b0;
            mpie_q           <= 1'b0;
            spp_q            <= 1'b0;
            mpp_q            <= PRIV_M;
            medeleg_q        <= 16'h0000;
            mtvec_q          <= RESET_VECTOR[XLEN-1:0];
            stvec_q          <= {XLEN{1'b0}};
            mepc_q           <= {XLEN{1'b0}};
            sepc_q           <= {XLEN{1'b0}};
            mcause_q         <= {XLEN{1'b0}};
            scause_q         <= {XLEN{1'b0}};
            mtval_q          <= {XLEN{1'b0}};
            stval_q          <= {XLEN{1'b0}};
            redirect_pc_q    <= {XLEN{1'b0}};
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            if (csr_wr_s) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        sie_q  <= csr_wdata_i[1];
                        mie_q  <= csr_wdata_i[3];
                        spie_q <= csr_wdata_i[5];
                        mpie_q <= csr_wdata_i[7];
                        spp_q  <= csr_wdata_i[8];
                        mpp_q  <= wr_mpp_s;
                    end
                    CSR_MEDELEG: medeleg_q <= csr_wdata_i[15:0] & 16'hF7FF;
                    CSR_MTVEC:   mtvec_q   <= csr_wdata_i & MASK_B10;
                    CSR_MEPC:    mepc_q    <= csr_wdata_i & MASK_B0;
                    CSR_MCAUSE:  mcause_q  <= csr_wdata_i;
                    CSR_MTVAL:   mtval_q   <= csr_wdata_i;
                    CSR_STVEC:   stvec_q   <= csr_wdata_i & MASK_B10;
                    CSR_SEPC:    sepc_q    <= csr_wdata_i & MASK_B0;
                    CSR_SCAUSE:  scause_q  <= csr_wdata_i;
                    CSR_STVAL:   stval_q   <= csr_wdata_i;
                    default: ;
                endcase
            end

            // Later assignments override the CSR write on the fields they touch
            if (take_exc_s) begin
                if (deleg_s) begin
                    sepc_q   <= epc_s;
                    scause_q <= cause_s;
                    stval_q  <= exception_val_i;
                    spie_q   <= sie_q;
                    sie_q    <= 1'b0;
                    spp_q    <= priv_q[0];
                    priv_q   <= PRIV_S;
                end else begin
                    mepc_q   <= epc_s;
                    mcause_q <= cause_s;
                    mtval_q  <= exception_val_i;
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                    mpp_q    <= priv_q;
                    priv_q   <= PRIV_M;
                end
            end else if (take_mret_s) begin
                priv_q <= mpp_q;
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
                mpp_q  <= PRIV_U;
            end else if (take_sret_s) begin
                priv_q <= {1'b0, spp_q};
                sie_q  <= spie_q;
                spie_q <= 1'b1;
                spp_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (take_exc_s || take_mret_s || take_sret_s) begin
                        state_q          <= ST_REDIRECT;
                        redirect_pc_q    <= redirect_pc_d;
                        redirect_valid_q <= 1'b1;
                        flush_q          <= 1'b1;
                        busy_q           <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q          <= ST_IDLE;
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b0;
                        busy_q           <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign busy_o           = busy_q;
    assign current_priv_o   = priv_q;
    assign mstatus_mie_o    = mie_q;
    assign mstatus_sie_o    = sie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: expected redirect targets are queued when an event
// is driven and compared when IF accepts the redirect; CSR state is read back.
module tb_trap_controller;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            exception = 1'b0;
    logic [4:0]      exception_code = 5'd0;
    logic [XLEN-1:0] exception_pc = 32'h0;
    logic [XLEN-1:0] exception_val = 32'h0;
    logic            mret = 1'b0;
    logic            sret = 1'b0;
    logic            csr_we = 1'b0;
    logic [11:0]     csr_addr = 12'h000;
    logic [XLEN-1:0] csr_wdata = 32'h0;
    logic [XLEN-1:0] csr_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready = 1'b1;
    logic            flush;
    logic            busy;
    logic [1:0]      current_priv;
    logic            mstatus_mie;
    logic            mstatus_sie;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    trap_controller #(.XLEN(XLEN)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .exception_i      (exception),
        .exception_code_i (exception_code),
        .exception_pc_i   (exception_pc),
        .exception_val_i  (exception_val),
        .mret_i           (mret),
        .sret_i           (sret),
        .csr_we_i         (csr_we),
        .csr_addr_i       (csr_addr),
        .csr_wdata_i      (csr_wdata),
        .csr_rdata_o      (csr_rdata),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .redirect_ready_i (redirect_ready),
        .flush_o          (flush),
        .busy_o           (busy),
        .current_priv_o   (current_priv),
        .mstatus_mie_o    (mstatus_mie),
        .mstatus_sie_o    (mstatus_sie)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every accepted redirect must match the oldest queued target
    always @(negedge clk) begin
        if (!reset && redirect_valid && redirect_ready) begin
            check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                check("sb_redirect_pc", redirect_pc, exp_q.pop_front());
                check("sb_flush", flush, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic fire(input logic e, input logic [4:0] code, input logic [31:0] pc,
                        input logic [31:0] val, input logic m, input logic s,
                        input logic push, input logic [31:0] tgt);
        exception = e; exception_code = code; exception_pc = pc; exception_val = val;
        mret = m; sret = s;
        if (push) exp_q.push_back(tgt);
        tick();
        exception = 1'b0; mret = 1'b0; sret = 1'b0;
        check("ev_redirect_valid", redirect_valid, 1);
        check("ev_flush", flush, 1);
        check("ev_busy", busy, 1);
        check("ev_redirect_pc", redirect_pc, tgt);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check("rst_valid", redirect_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_busy", busy, 0);
        check("rst_priv", current_priv, 2'b11);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h8000_0000);
        rd("rst_mepc", 12'h341, 32'h0);

        // M-mode ECALL
        csr_wr(12'h305, 32'h8000_0104);
        rd("mtvec_wr", 12'h305, 32'h8000_0104);
        csr_wr(12'h300, 32'h0000_1808);
        fire(1'b1, 5'd11, 32'h8000_0200, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0104);
        wait_idle();
        rd("ecall_mepc", 12'h341, 32'h8000_0200);
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);
        check("ecall_mie", mstatus_mie, 0);

        // Delegated ECALL from U
        csr_wr(12'h302, 32'h0000_0100);
        csr_wr(12'h105, 32'h8000_1000);
        csr_wr(12'h341, 32'h8000_0500);
        csr_wr(12'h300, 32'h0000_0080);
        fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0500);
        wait_idle();
        check("mret_to_u_priv", current_priv, 2'b00);
        rd("mret_to_u_mstatus", 12'h300, 32'h0000_0088);
        fire(1'b1, 5'd8, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_1000);
        wait_idle();
        check("deleg_priv", current_priv, 2'b01);
        rd("deleg_sepc", 12'h141, 32'h0000_0400);
        rd("deleg_scause", 12'h142, 32'd8);
        rd("deleg_mstatus", 12'h300, 32'h0000_0088);
        rd("deleg_mcause_kept", 12'h342, 32'd11);

        // Same flow without delegation
        csr_wr(12'h302, 32'h0);
        csr_wr(12'h300, 32'h0000_0088);
        fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0500);
        wait_idle();
        check("mret2_priv", current_priv, 2'b00);
        fire(1'b1, 5'd8, 32'h0000_0404, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0104);
        wait_idle();
        check("nodeleg_priv", current_priv, 2'b11);
        rd("nodeleg_mepc", 12'h341, 32'h0000_0404);
        rd("nodeleg_mcause", 12'h342, 32'd8);
        rd("nodeleg_mstatus", 12'h300, 32'h0000_0080);

        // SRET, then trap from S with odd PC
        csr_wr(12'h141, 32'h8000_2000);
        csr_wr(12'h300, 32'h0000_01A0);
        fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_2000);
        wait_idle();
        check("sret_priv", current_priv, 2'b01);
        check("sret_sie", mstatus_sie, 1);
        rd("sret_mstatus", 12'h300, 32'h0000_00A2);
        fire(1'b1, 5'd2, 32'h8000_2001, 32'h55, 1'b0, 1'b0, 1'b1, 32'h8000_0104);
        wait_idle();
        rd("s2m_mepc", 12'h341, 32'h8000_2000);
        rd("s2m_mtval", 12'h343, 32'h55);
        rd("s2m_mstatus", 12'h300, 32'h0000_0822);

        // MRET to S
        csr_wr(12'h341, 32'h8000_0300);
        csr_wr(12'h300, 32'h0000_0880);
        fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0300);
        wait_idle();
        check("mret_s_priv", current_priv, 2'b01);
        check("mret_s_mie", mstatus_mie, 1);
        rd("mret_s_mstatus", 12'h300, 32'h0000_0088);

        // Back-pressure with an ignored exception during the wait
        redirect_ready = 1'b0;
        fire(1'b1, 5'd5, 32'h0000_0100, 32'h7, 1'b0, 1'b0, 1'b1, 32'h8000_0104);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", redirect_valid, 1);
            check("stall_flush", flush, 1);
            check("stall_pc", redirect_pc, 32'h8000_0104);
            if (i == 1) begin
                exception = 1'b1; exception_code = 5'd13; exception_pc = 32'h998;
            end
            tick();
            exception = 1'b0;
        end
        rd("stall_mcause", 12'h342, 32'd5);
        rd("stall_mepc", 12'h341, 32'h0000_0100);
        redirect_ready = 1'b1;
        tick();
        check("release_busy", busy, 0);
        check("release_valid", redirect_valid, 0);
        check("release_flush", flush, 0);

        // Exception + MRET + CSR write collide
        csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_1234;
        fire(1'b1, 5'd2, 32'h8000_0600, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h8000_0104);
        csr_we = 1'b0;
        wait_idle();
        rd("coll_mepc", 12'h341, 32'h8000_0600);
        rd("coll_mtval", 12'h343, 32'hDEAD_BEEF);
        rd("coll_mcause", 12'h342, 32'd2);
        rd("coll_mstatus", 12'h300, 32'h0000_1800);
        check("coll_priv", current_priv, 2'b11);

        // WARL fields
        csr_wr(12'h300, 32'h0000_1000);
        rd("warl_mpp", 12'h300, 32'h0);
        csr_wr(12'h341, 32'h0000_1235);
        rd("warl_mepc", 12'h341, 32'h0000_1234);
        csr_wr(12'h302, 32'h0000_FFFF);
        rd("warl_medeleg", 12'h302, 32'h0000_F7FF);
        csr_wr(12'h305, 32'h8000_0107);
        rd("warl_mtvec", 12'h305, 32'h8000_0104);
        rd("unowned_csr", 12'h7C0, 32'h0);

        // Reset during REDIRECT drops the redirect
        csr_wr(12'h300, 32'h0);
        redirect_ready = 1'b0;
        fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_1234);
        check("pre_rst_priv", current_priv, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", redirect_valid, 0);
        check("mid_rst_flush", flush, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_priv", current_priv, 2'b11);
        rd("mid_rst_mtvec", 12'h305, 32'h8000_0000);
        rd("mid_rst_mstatus", 12'h300, 32'h0000_1800);
        redirect_ready = 1'b1;
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
